// File: rtl/dds_pkg.sv
// Shared definitions for the DDS block family (dds, key_control, dds_sweep_ctrl).
//   FREQ_W / WAVE_W : widths of the phase-increment word and the waveform select
//   MODE_*          : sweep mode encodings carried on the 2-bit mode input
//   ST_*            : sweep controller FSM state encodings
//   dir_t           : step direction for the step/clamp helper
package dds_pkg;

   localparam int FREQ_W = 32;
   localparam int WAVE_W = 4;

   localparam logic [1:0] MODE_SINGLE   = 2'd0;
   localparam logic [1:0] MODE_REPEAT   = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;
   localparam logic [1:0] MODE_RSVD     = 2'd3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN_UP = 2'd1;
   localparam logic [1:0] ST_RUN_DN = 2'd2;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_t;

endpackage

// File: rtl/dds_step_clamp.sv
// Combinational step-and-saturate for the sweep frequency word.
//   cur       : current frequency word
//   step      : step size
//   bound     : stop value when stepping up, start value when stepping down
//   dir       : DIR_UP adds step, DIR_DN subtracts it
//   next_word : stepped word, saturated to bound on overshoot or carry/borrow
module dds_step_clamp
   import dds_pkg::*;
(
   input  logic [FREQ_W-1:0] cur,
   input  logic [FREQ_W-1:0] step,
   input  logic [FREQ_W-1:0] bound,
   input  dir_t              dir,
   output logic [FREQ_W-1:0] next_word
);

   // One extra bit so a carry out of the top (or a borrow) is visible and
   // forces saturation instead of wrapping to a small/large value.
   logic [FREQ_W:0] sum;
   logic [FREQ_W:0] diff;

   always_comb begin
      sum       = {1'b0, cur} + {1'b0, step};
      diff      = {1'b0, cur} - {1'b0, step};
      next_word = bound;
      if (dir == DIR_UP) begin
         if (!sum[FREQ_W] && (sum[FREQ_W-1:0] <= bound))
            next_word = sum[FREQ_W-1:0];
      end else begin
         if (!diff[FREQ_W] && (diff[FREQ_W-1:0] >= bound))
            next_word = diff[FREQ_W-1:0];
      end
   end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler feeding the DDS phase-increment word.
// Steps freq_word from freq_start to freq_stop by freq_step, holding each
// word for max(dwell,1) clocks, and latches the waveform select at start.
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   start, abort         : sweep request / sweep stop (abort wins over start)
//   mode                 : single / repeat / ping-pong (3 is rejected)
//   freq_start/stop/step : sweep configuration, sampled only when accepted
//   dwell, wave_in       : hold time per word, waveform select to latch
//   freq_word            : registered frequency word to the DDS
//   wave_select          : registered waveform select to the DDS
//   busy                 : sweep in progress
//   sweep_done, cfg_err  : one-cycle pulses (single sweep finished / start rejected)
//   state_dbg            : current FSM state
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter logic [FREQ_W-1:0] FREQ_DEFAULT = 32'd2000,
   parameter int                DWELL_W      = 24
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               start,
   input  logic               abort,
   input  logic [1:0]         mode,
   input  logic [FREQ_W-1:0]  freq_start,
   input  logic [FREQ_W-1:0]  freq_stop,
   input  logic [FREQ_W-1:0]  freq_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [WAVE_W-1:0]  wave_in,
   output logic [FREQ_W-1:0]  freq_word,
   output logic [WAVE_W-1:0]  wave_select,
   output logic               busy,
   output logic               sweep_done,
   output logic               cfg_err,
   output logic [1:0]         state_dbg
);

   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   // Handshake: start is a request that is taken only while busy is low
   // (busy acts as the inverse of ready). An accepted start raises busy on
   // the next clock; a rejected one pulses cfg_err instead. Requests made
   // while busy is high are dropped, not queued.

   logic [1:0]         state;
   logic [FREQ_W-1:0]  cfg_start;
   logic [FREQ_W-1:0]  cfg_stop;
   logic [FREQ_W-1:0]  cfg_step;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [1:0]         cfg_mode;
   logic [DWELL_W-1:0] dwell_cnt;

   logic               cfg_bad;
   logic [DWELL_W-1:0] dwell_in_ld;
   logic [DWELL_W-1:0] dwell_ld;
   logic               at_stop;
   logic               at_start;
   dir_t               clamp_dir;
   logic [FREQ_W-1:0]  clamp_bound;
   logic [FREQ_W-1:0]  clamp_next;

   always_comb begin
      cfg_bad     = (freq_step == '0) || (freq_start > freq_stop) || (mode == MODE_RSVD);
      // Reload value is dwell-1 so the word is held dwell clocks; 0 acts as 1.
      dwell_in_ld = (dwell == '0) ? '0 : dwell - DWELL_ONE;
      dwell_ld    = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_ONE;
      at_stop     = (freq_word == cfg_stop);
      at_start    = (freq_word == cfg_start);
      // Step up while climbing, and also from start when turning around at
      // the bottom; step down otherwise (descending, or turning at stop).
      if (((state == ST_RUN_UP) && !at_stop) || ((state == ST_RUN_DN) && at_start))
         clamp_dir = DIR_UP;
      else
         clamp_dir = DIR_DN;
      clamp_bound = (clamp_dir == DIR_UP) ? cfg_stop : cfg_start;
   end

   dds_step_clamp u_step_clamp (
      .cur       (freq_word),
      .step      (cfg_step),
      .bound     (clamp_bound),
      .dir       (clamp_dir),
      .next_word (clamp_next)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         freq_word   <= FREQ_DEFAULT;
         wave_select <= '0;
         busy        <= 1'b0;
         sweep_done  <= 1'b0;
         cfg_err     <= 1'b0;
         cfg_start   <= '0;
         cfg_stop    <= '0;
         cfg_step    <= '0;
         cfg_dwell   <= '0;
         cfg_mode    <= MODE_SINGLE;
         dwell_cnt   <= '0;
      end else begin
         sweep_done <= 1'b0;
         cfg_err    <= 1'b0;
         if (abort) begin
            // Freeze the outputs where they are; no done pulse.
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (cfg_bad) begin
                        cfg_err <= 1'b1;
                     end else begin
                        cfg_start   <= freq_start;
                        cfg_stop    <= freq_stop;
                        cfg_step    <= freq_step;
                        cfg_dwell   <= dwell;
                        cfg_mode    <= mode;
                        freq_word   <= freq_start;
                        wave_select <= wave_in;
                        dwell_cnt   <= dwell_in_ld;
                        busy        <= 1'b1;
                        state       <= ST_RUN_UP;
                     end
                  end
               end
               ST_RUN_UP: begin
                  if (dwell_cnt != '0) begin
                     dwell_cnt <= dwell_cnt - DWELL_ONE;
                  end else begin
                     dwell_cnt <= dwell_ld;
                     if (!at_stop) begin
                        freq_word <= clamp_next;
                     end else begin
                        case (cfg_mode)
                           MODE_REPEAT: freq_word <= cfg_start;
                           MODE_PINGPONG: begin
                              // start==stop: nothing to turn around to, hold.
                              if (cfg_start != cfg_stop) begin
                                 state     <= ST_RUN_DN;
                                 freq_word <= clamp_next;
                              end
                           end
                           default: begin
                              state      <= ST_IDLE;
                              busy       <= 1'b0;
                              sweep_done <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               ST_RUN_DN: begin
                  if (dwell_cnt != '0) begin
                     dwell_cnt <= dwell_cnt - DWELL_ONE;
                  end else begin
                     dwell_cnt <= dwell_ld;
                     freq_word <= clamp_next;
                     if (at_start)
                        state <= ST_RUN_UP;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a reference model expands each sweep request into
// the per-clock output trace it should produce; a monitor compares the DUT
// outputs against that trace one clock at a time.
module tb_dds_sweep_ctrl;

   logic        clk;
   logic        sys_rst;
   logic        start;
   logic        abort;
   logic [1:0]  mode;
   logic [31:0] freq_start;
   logic [31:0] freq_stop;
   logic [31:0] freq_step;
   logic [23:0] dwell;
   logic [3:0]  wave_in;
   logic [31:0] freq_word;
   logic [3:0]  wave_select;
   logic        busy;
   logic        sweep_done;
   logic        cfg_err;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // entry = {busy, sweep_done, cfg_err, wave_select[3:0], freq_word[31:0]}
   logic [38:0] exp_q[$];
   logic [38:0] mon_exp;
   logic [38:0] mon_act;

   logic [31:0] m_word;
   logic [3:0]  m_wave;

   dds_sweep_ctrl dut (
      .sys_clk     (clk),
      .sys_rst     (sys_rst),
      .start       (start),
      .abort       (abort),
      .mode        (mode),
      .freq_start  (freq_start),
      .freq_stop   (freq_stop),
      .freq_step   (freq_step),
      .dwell       (dwell),
      .wave_in     (wave_in),
      .freq_word   (freq_word),
      .wave_select (wave_select),
      .busy        (busy),
      .sweep_done  (sweep_done),
      .cfg_err     (cfg_err),
      .state_dbg   (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [38:0] pack(input logic b, input logic d, input logic e,
                                        input logic [3:0] w, input logic [31:0] f);
      return {b, d, e, w, f};
   endfunction

   // monitor / scoreboard
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {busy, sweep_done, cfg_err, wave_select, freq_word};
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL outputs @%0t: got busy=%b done=%b err=%b wave=%h word=%h, expected busy=%b done=%b err=%b wave=%h word=%h",
                     $time, mon_act[38], mon_act[37], mon_act[36], mon_act[35:32], mon_act[31:0],
                     mon_exp[38], mon_exp[37], mon_exp[36], mon_exp[35:32], mon_exp[31:0]);
         end
      end
   end

   // Issue one start request and drive the following clocks. The expected
   // output for every clock is derived from the sweep rules: walk the word
   // list with plain 64-bit arithmetic, repeat each word for its dwell, then
   // overlay the effect of an abort or reset at the requested clock.
   task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                            input logic [23:0] dw, input logic [1:0] md, input logic [3:0] wv,
                            input int ncyc, input int abort_req, input int rst_at);
      logic [38:0] tr[$];
      logic [38:0] base;
      logic [38:0] last;
      longint      cur, lfs, lfe, lst;
      bit          up, fin, ok;
      int          d, abort_at;
      lfs = fs;
      lfe = fe;
      lst = st;
      ok  = (st != 0) && (fs <= fe) && (md != 2'd3);
      d   = (dw == 0) ? 1 : int'(dw);
      abort_at = abort_req;
      if (!ok) begin
         tr.push_back(pack(1'b0, 1'b0, 1'b1, m_wave, m_word));
         while (tr.size() < ncyc) tr.push_back(pack(1'b0, 1'b0, 1'b0, m_wave, m_word));
      end else begin
         cur = lfs;
         up  = 1'b1;
         fin = 1'b0;
         while (!fin && ((tr.size() < ncyc) || (md == 2'd0))) begin
            for (int i = 0; i < d; i++) tr.push_back(pack(1'b1, 1'b0, 1'b0, wv, cur[31:0]));
            if (up) begin
               if (cur == lfe) begin
                  if (md == 2'd0) fin = 1'b1;
                  else if (md == 2'd1) cur = lfs;
                  else if (lfs != lfe) begin
                     up  = 1'b0;
                     cur = (cur - lst < lfs) ? lfs : cur - lst;
                  end
               end else begin
                  cur = (cur + lst > lfe) ? lfe : cur + lst;
               end
            end else begin
               if (cur == lfs) begin
                  up  = 1'b1;
                  cur = (cur + lst > lfe) ? lfe : cur + lst;
               end else begin
                  cur = (cur - lst < lfs) ? lfs : cur - lst;
               end
            end
         end
         if (fin) tr.push_back(pack(1'b0, 1'b1, 1'b0, wv, fe));
         last = tr[tr.size()-1];
         while (tr.size() < ncyc) tr.push_back(pack(1'b0, 1'b0, 1'b0, wv, last[31:0]));
         // never leave a continuous sweep running into the next request
         if (!fin && abort_at < 0 && rst_at < 0) abort_at = tr.size() - 1;
      end
      if (abort_at >= int'(tr.size())) abort_at = tr.size() - 1;
      if (abort_at > 0) begin
         base = tr[abort_at-1];
         if (base[38])
            for (int k = abort_at; k < tr.size(); k++)
               tr[k] = pack(1'b0, 1'b0, 1'b0, base[35:32], base[31:0]);
      end
      if (rst_at > 0 && rst_at < int'(tr.size()))
         for (int k = rst_at; k < tr.size(); k++)
            tr[k] = pack(1'b0, 1'b0, 1'b0, 4'h0, 32'd2000);

      // drive
      @(negedge clk);
      start      = 1'b1;
      abort      = 1'b0;
      sys_rst    = 1'b0;
      freq_start = fs;
      freq_stop  = fe;
      freq_step  = st;
      dwell      = dw;
      mode       = md;
      wave_in    = wv;
      foreach (tr[k]) exp_q.push_back(tr[k]);
      for (int k = 1; k < tr.size(); k++) begin
         @(negedge clk);
         base       = tr[k-1];
         // extra start requests (with junk config) only while a sweep runs
         start      = base[38] ? 1'($urandom_range(0, 1)) : 1'b0;
         freq_start = $urandom;
         freq_stop  = $urandom;
         freq_step  = 32'($urandom_range(0, 3));
         dwell      = 24'($urandom_range(0, 2));
         mode       = 2'($urandom_range(0, 3));
         wave_in    = 4'($urandom);
         abort      = (k == abort_at);
         sys_rst    = (k == rst_at);
      end
      last   = tr[tr.size()-1];
      m_word = last[31:0];
      m_wave = last[35:32];
   endtask

   initial begin
      logic [31:0] fs, fe, st;
      longint      span;
      sys_rst    = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      mode       = 2'd0;
      freq_start = '0;
      freq_stop  = '0;
      freq_step  = '0;
      dwell      = '0;
      wave_in    = '0;
      m_word     = 32'd2000;
      m_wave     = 4'h0;
      // reset values
      repeat (3) exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 4'h0, 32'd2000));
      repeat (3) @(negedge clk);
      sys_rst = 1'b0;

      run_sweep(32'd100, 32'd130, 32'd10, 24'd3, 2'd0, 4'h5, 15, -1, -1);
      run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd1, 2'd0, 4'hA, 5, -1, -1);
      run_sweep(32'd0, 32'd25, 32'd10, 24'd1, 2'd2, 4'h3, 20, 12, -1);
      run_sweep(32'd5, 32'd9, 32'd0, 24'd1, 2'd0, 4'h1, 3, -1, -1);
      run_sweep(32'd50, 32'd40, 32'd5, 24'd1, 2'd0, 4'h2, 3, -1, -1);
      run_sweep(32'd1, 32'd9, 32'd1, 24'd1, 2'd3, 4'h7, 3, -1, -1);
      run_sweep(32'd7, 32'd10, 32'd1, 24'd0, 2'd0, 4'h6, 8, -1, -1);
      run_sweep(32'd100, 32'd200, 32'd25, 24'd2, 2'd1, 4'h9, 16, -1, 9);
      run_sweep(32'd300, 32'd300, 32'd1, 24'd2, 2'd0, 4'h2, 6, -1, -1);
      run_sweep(32'd300, 32'd300, 32'd1, 24'd2, 2'd1, 4'h4, 10, -1, -1);
      run_sweep(32'd1000, 32'd1040, 32'd7, 24'd1, 2'd2, 4'hC, 30, 25, -1);

      for (int r = 0; r < 14; r++) begin
         fs   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 500))
                                            : 32'hFFFF_FF80 + 32'($urandom_range(0, 64));
         span = longint'(fs) + $urandom_range(0, 120);
         fe   = (span > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : span[31:0];
         st   = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 50));
         run_sweep(fs, fe, st, 24'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   4'($urandom), 40,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : -1, -1);
      end

      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
